// File: rtl/count_uart_reporter_pkg.sv
// Shared types and sizing for the count snapshot UART reporter.
package count_report_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/count_uart_reporter_if.sv
// Count/strobe inputs and serial/status outputs of the reporter, bundled for the top.
interface count_uart_reporter_if
  import count_report_pkg::*;
  ;

  logic [DATA_BITS-1:0] count;
  logic                 sample_req;
  logic                 tx;
  logic                 busy;
  logic [LEVEL_W-1:0]   fifo_level;
  logic                 overflow;

  modport master (
    output count, sample_req,
    input  tx, busy, fifo_level, overflow
  );

  modport slave (
    input  count, sample_req,
    output tx, busy, fifo_level, overflow
  );

endinterface

// File: rtl/count_uart_reporter_fifo.sv
// Snapshot FIFO: power-of-two depth, head word visible combinationally,
// a push into a full FIFO is still taken when the head is popped on the same edge.
module count_snap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/count_uart_reporter.sv
// Captures counter snapshots on sample_req and streams them out 8N1, LSB first,
// on a registered tx line; frames are sent back-to-back while snapshots are queued.
module count_uart_reporter
  import count_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = count_report_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  count_uart_reporter_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 tx_q;
  logic                 busy_q;
  logic                 overflow_q;
  logic [LW-1:0]        level;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  // The head is taken either from idle or at the very end of a stop bit,
  // which is what makes consecutive frames abut with no idle gap.
  assign pop = !empty && ((state == IDLE) || ((state == STOP) && baud_wrap));

  count_snap_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.sample_req),
    .pop   (pop),
    .wdata (bus.count),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.sample_req && full && !pop) begin
        overflow_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!empty) begin
            shift  <= head;
            state  <= START;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = LEVEL_W'(level);

endmodule

// File: tb/tb_count_uart_reporter.sv
// Directed bench for count_uart_reporter with a byte scoreboard fed by a tx decoder.
module tb_count_uart_reporter;

  logic clk = 1'b0;
  logic rstn;

  count_uart_reporter_if bus();

  count_uart_reporter #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // tx decoder: frame starts on the first low sample, each bit is sampled mid-bit
  bit         in_frame = 1'b0;
  int         k = 0;
  logic [9:0] fbits;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (bus.tx === 1'b0) begin
        in_frame = 1'b1;
        k = 0;
      end
    end else begin
      k++;
    end
    if (in_frame) begin
      if (k % 4 == 2) fbits[k/4] = bus.tx;
      if (k == 39) begin
        in_frame = 1'b0;
        rx_byte = fbits[8:1];
        chk("start_bit", 32'(fbits[0]), 32'd0);
        chk("stop_bit", 32'(fbits[9]), 32'd1);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  int run = 0;
  int last_run = 0;

  always @(negedge clk) begin
    if (bus.busy === 1'b1) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy !== 1'b0 && g < 2000) begin
      step();
      g++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv[6];
    int seen_busy;
    logic [9:0] fr;
    lv = '{1, 1, 2, 3, 4, 4};

    rstn = 1'b0;
    bus.sample_req = 1'b0;
    bus.count = 8'h00;

    // reset held with sample_req toggling
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_tx", 32'(bus.tx), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_level", 32'(bus.fifo_level), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      bus.sample_req = i[0];
      bus.count = 8'(i * 7);
    end
    rstn = 1'b1;
    bus.sample_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_tx", 32'(bus.tx), 32'd1);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_level", 32'(bus.fifo_level), 32'd0);
    end

    // single snapshot, exact waveform
    bus.count = 8'hA5;
    bus.sample_req = 1'b1;
    exp_q.push_back(8'hA5);
    step();
    bus.sample_req = 1'b0;
    chk("single_level", 32'(bus.fifo_level), 32'd1);
    chk("single_tx_idle", 32'(bus.tx), 32'd1);
    chk("single_busy_idle", 32'(bus.busy), 32'd0);
    step();
    fr = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 40; c++) begin
      chk("a5_tx", 32'(bus.tx), 32'(fr[c/4]));
      chk("a5_busy", 32'(bus.busy), 32'd1);
      step();
    end
    chk("a5_end_busy", 32'(bus.busy), 32'd0);
    chk("a5_end_tx", 32'(bus.tx), 32'd1);
    wait_idle();
    chk("a5_busy_len", 32'(last_run), 32'd40);
    chk("a5_q_empty", 32'(exp_q.size()), 32'd0);

    // back-to-back frames
    for (int i = 1; i <= 3; i++) begin
      bus.count = 8'(i);
      bus.sample_req = 1'b1;
      exp_q.push_back(8'(i));
      step();
    end
    bus.sample_req = 1'b0;
    wait_idle();
    chk("b2b_busy_len", 32'(last_run), 32'd120);
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // overflow from idle
    for (int i = 0; i < 6; i++) begin
      bus.count = 8'(10 + i);
      bus.sample_req = 1'b1;
      if (i < 5) exp_q.push_back(8'(10 + i));
      step();
      chk("ovf_level", 32'(bus.fifo_level), 32'(lv[i]));
      chk("ovf_flag", 32'(bus.overflow), (i == 5) ? 32'd1 : 32'd0);
    end
    bus.sample_req = 1'b0;
    wait_idle();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_busy_len", 32'(last_run), 32'd200);
    chk("ovf_q_empty", 32'(exp_q.size()), 32'd0);
    rstn = 1'b0;
    step();
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    chk("ovf_rst_level", 32'(bus.fifo_level), 32'd0);
    rstn = 1'b1;
    step();

    // full FIFO with push coincident with the stop-end pop
    bus.count = 8'd20;
    bus.sample_req = 1'b1;
    exp_q.push_back(8'd20);
    step();
    for (int i = 1; i <= 4; i++) begin
      bus.count = 8'(20 + i);
      exp_q.push_back(8'(20 + i));
      step();
      chk("full_fill_level", 32'(bus.fifo_level), 32'(i));
    end
    bus.sample_req = 1'b0;
    repeat (36) step();
    chk("full_pre_level", 32'(bus.fifo_level), 32'd4);
    chk("full_pre_stop", 32'(bus.tx), 32'd1);
    bus.count = 8'd25;
    bus.sample_req = 1'b1;
    exp_q.push_back(8'd25);
    step();
    bus.sample_req = 1'b0;
    chk("full_pop_level", 32'(bus.fifo_level), 32'd4);
    chk("full_pop_ovf", 32'(bus.overflow), 32'd0);
    chk("full_pop_start", 32'(bus.tx), 32'd0);
    wait_idle();
    chk("full_busy_len", 32'(last_run), 32'd240);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    // reset during data bit 3
    bus.count = 8'h3C;
    bus.sample_req = 1'b1;
    step();
    bus.count = 8'h55;
    step();
    bus.sample_req = 1'b0;
    chk("mid_level", 32'(bus.fifo_level), 32'd1);
    chk("mid_start", 32'(bus.tx), 32'd0);
    repeat (17) step();
    chk("mid_bit3", 32'(bus.tx), 32'd1);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    step();
    chk("mid_rst_tx", 32'(bus.tx), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    rstn = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) seen_busy++;
    end
    chk("mid_no_frames", 32'(seen_busy), 32'd0);
    chk("mid_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
